// File: rtl/control_botones_ajuste_pkg.sv
// rtl/control_botones_ajuste_pkg.sv - field codes and button indices shared by the adjust front end
package control_botones_ajuste_pkg;

    typedef logic [3:0] field_t;

    // Field codes are shared with the two-digit field counters downstream.
    localparam field_t FIELD_NONE  = 4'd0;
    localparam field_t FIELD_HOUR  = 4'd1;
    localparam field_t FIELD_MIN   = 4'd2;
    localparam field_t FIELD_SEC   = 4'd3;
    localparam field_t FIELD_YEAR  = 4'd4;
    localparam field_t FIELD_MONTH = 4'd5;
    localparam field_t FIELD_DAY   = 4'd6;
    localparam field_t FIELD_FIRST = FIELD_HOUR;
    localparam field_t FIELD_LAST  = FIELD_DAY;

    localparam int NUM_BTN   = 5;
    localparam int BTN_DOWN  = 0;
    localparam int BTN_UP    = 1;
    localparam int BTN_RIGHT = 2;
    localparam int BTN_LEFT  = 3;
    localparam int BTN_MODE  = 4;

    function automatic field_t next_field(input field_t f);
        return (f == FIELD_LAST) ? FIELD_FIRST : field_t'(f + 4'd1);
    endfunction

    function automatic field_t prev_field(input field_t f);
        return (f == FIELD_FIRST) ? FIELD_LAST : field_t'(f - 4'd1);
    endfunction

endpackage

// File: rtl/control_botones_ajuste_debounce.sv
// rtl/control_botones_ajuste_debounce.sv - per-button synchronizer, debouncer and rising-edge pulse
module debounce_boton #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic db,
    output logic pe
);

    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic          db_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            db     <= 1'b0;
            db_d   <= 1'b0;
            cnt    <= '0;
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;
            db_d   <= db;
            // Any sample agreeing with the accepted level restarts the run.
            if (sync_b == db) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                db  <= ~db;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign pe = db & ~db_d;

endmodule

// File: rtl/control_botones_ajuste.sv
// rtl/control_botones_ajuste.sv - debounced buttons driving the date/time field-select FSM
module control_botones_ajuste
    import control_botones_ajuste_pkg::*;
#(
    parameter int          DB_CYCLES      = 1_000_000,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd3_000_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [3:0] en_count,
    output logic       enUP,
    output logic       enDOWN,
    output logic       adjust_active
);

    typedef enum logic {
        ST_IDLE,
        ST_ADJUST
    } state_t;

    logic [NUM_BTN-1:0] raw_vec;
    logic [NUM_BTN-1:0] db_vec;
    logic [NUM_BTN-1:0] pe_vec;

    assign raw_vec[BTN_DOWN]  = btn_down;
    assign raw_vec[BTN_UP]    = btn_up;
    assign raw_vec[BTN_RIGHT] = btn_right;
    assign raw_vec[BTN_LEFT]  = btn_left;
    assign raw_vec[BTN_MODE]  = btn_mode;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        debounce_boton #(
            .DB_CYCLES(DB_CYCLES)
        ) u_db (
            .clk  (clk),
            .reset(reset),
            .btn  (raw_vec[i]),
            .db   (db_vec[i]),
            .pe   (pe_vec[i])
        );
    end

    // Up/down act on levels, so their edge pulses are not consumed.
    logic unused_pe;
    assign unused_pe = pe_vec[BTN_UP] ^ pe_vec[BTN_DOWN];

    state_t      state;
    logic [31:0] idle_cnt;
    logic        any_held;
    logic        step_right;
    logic        step_left;
    logic        timed_out;
    logic        want_up;
    logic        want_down;

    assign any_held   = |db_vec;
    assign step_right = pe_vec[BTN_RIGHT] & ~pe_vec[BTN_LEFT];
    assign step_left  = pe_vec[BTN_LEFT] & ~pe_vec[BTN_RIGHT];
    assign timed_out  = ~any_held & (idle_cnt == TIMEOUT_CYCLES - 32'd1);
    assign want_up    = db_vec[BTN_UP] & ~db_vec[BTN_DOWN];
    assign want_down  = db_vec[BTN_DOWN] & ~db_vec[BTN_UP];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= ST_IDLE;
            idle_cnt      <= '0;
            en_count      <= FIELD_NONE;
            adjust_active <= 1'b0;
            enUP          <= 1'b0;
            enDOWN        <= 1'b0;
        end else begin
            enUP   <= 1'b0;
            enDOWN <= 1'b0;
            case (state)
                ST_IDLE: begin
                    idle_cnt <= '0;
                    if (pe_vec[BTN_MODE]) begin
                        state         <= ST_ADJUST;
                        en_count      <= FIELD_FIRST;
                        adjust_active <= 1'b1;
                    end
                end
                ST_ADJUST: begin
                    // Mode beats left/right; leaving clears every output at once.
                    if (pe_vec[BTN_MODE] || timed_out) begin
                        state         <= ST_IDLE;
                        idle_cnt      <= '0;
                        en_count      <= FIELD_NONE;
                        adjust_active <= 1'b0;
                    end else begin
                        idle_cnt <= any_held ? 32'd0 : idle_cnt + 32'd1;
                        // Up/down stay quiet for the cycle the field moves.
                        if (step_right) begin
                            en_count <= next_field(en_count);
                        end else if (step_left) begin
                            en_count <= prev_field(en_count);
                        end else begin
                            enUP   <= want_up;
                            enDOWN <= want_down;
                        end
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    idle_cnt      <= '0;
                    en_count      <= FIELD_NONE;
                    adjust_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_botones_ajuste.sv
// tb/tb_control_botones_ajuste.sv - self-checking bench for control_botones_ajuste
module tb_control_botones_ajuste;

    localparam int DB = 4;
    localparam int TO = 50;

    logic       clk;
    logic       reset;
    logic [4:0] btns;   // {mode, left, right, up, down}
    logic [3:0] en_count;
    logic       enUP;
    logic       enDOWN;
    logic       adjust_active;

    int n_chk;
    int n_err;

    control_botones_ajuste #(
        .DB_CYCLES(DB),
        .TIMEOUT_CYCLES(32'd50)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_mode     (btns[4]),
        .btn_left     (btns[3]),
        .btn_right    (btns[2]),
        .btn_up       (btns[1]),
        .btn_down     (btns[0]),
        .en_count     (en_count),
        .enUP         (enUP),
        .enDOWN       (enDOWN),
        .adjust_active(adjust_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a button level is accepted once the last DB samples
    // seen through the two-stage synchronizer all disagree with it.
    logic [4:0] hist [0:DB+1];
    logic [4:0] m_db;
    logic [4:0] m_dbd;
    bit         m_adj;
    int         m_field;
    int         m_quiet;
    bit         m_up;
    bit         m_dn;

    task automatic model_edge();
        logic [4:0] pe;
        bit         diff;
        if (!reset) begin
            for (int i = 0; i <= DB + 1; i++) hist[i] = '0;
            m_db = '0; m_dbd = '0;
            m_adj = 0; m_field = 0; m_quiet = 0; m_up = 0; m_dn = 0;
            return;
        end
        pe = m_db & ~m_dbd;
        m_up = 0;
        m_dn = 0;
        if (!m_adj) begin
            m_quiet = 0;
            if (pe[4]) begin
                m_adj = 1;
                m_field = 1;
            end
        end else if (pe[4] || (m_db == 0 && m_quiet == TO - 1)) begin
            m_adj = 0;
            m_field = 0;
            m_quiet = 0;
        end else begin
            m_quiet = (m_db != 0) ? 0 : m_quiet + 1;
            if (pe[2] && !pe[3]) m_field = m_field % 6 + 1;
            else if (pe[3] && !pe[2]) m_field = (m_field + 4) % 6 + 1;
            else begin
                m_up = m_db[1] && !m_db[0];
                m_dn = m_db[0] && !m_db[1];
            end
        end
        for (int i = DB + 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = btns;
        m_dbd = m_db;
        for (int b = 0; b < 5; b++) begin
            diff = 1;
            for (int j = 2; j <= DB + 1; j++) if (hist[j][b] == m_db[b]) diff = 0;
            if (diff) m_db[b] = ~m_db[b];
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("model", {en_count, adjust_active, enUP, enDOWN},
            {m_field[3:0], m_adj, m_up, m_dn});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        btns = '0;
        reset = 1'b0;
        ticks(2);
        reset = 1'b1;
        ticks(1);
    endtask

    task automatic press(input logic [4:0] mask, input int hold, input int gap);
        btns = mask;
        ticks(hold);
        btns = '0;
        ticks(gap);
    endtask

    typedef struct {
        logic [4:0] mask;
        int         hold;
        int         gap;
        logic [3:0] exp_en;
        logic       exp_adj;
    } vec_t;

    vec_t vecs [13];

    initial begin
        n_chk = 0;
        n_err = 0;
        btns  = '0;
        reset = 1'b0;

        vecs[0]  = '{5'b10000, 6, 10, 4'd1, 1'b1};
        vecs[1]  = '{5'b00100, 6, 10, 4'd2, 1'b1};
        vecs[2]  = '{5'b00100, 6, 10, 4'd3, 1'b1};
        vecs[3]  = '{5'b01000, 6, 10, 4'd2, 1'b1};
        vecs[4]  = '{5'b01000, 6, 10, 4'd1, 1'b1};
        vecs[5]  = '{5'b01000, 6, 10, 4'd6, 1'b1};
        vecs[6]  = '{5'b00100, 6, 10, 4'd1, 1'b1};
        vecs[7]  = '{5'b01100, 6, 10, 4'd1, 1'b1};
        vecs[8]  = '{5'b01000, 6, 10, 4'd6, 1'b1};
        vecs[9]  = '{5'b01100, 6, 10, 4'd6, 1'b1};
        vecs[10] = '{5'b10100, 6, 10, 4'd0, 1'b0};
        vecs[11] = '{5'b00100, 6, 10, 4'd0, 1'b0};
        vecs[12] = '{5'b10000, 6, 10, 4'd1, 1'b1};

        // Reset with every button held, then release.
        btns = 5'b11111;
        ticks(3);
        chk("reset_outputs", {en_count, adjust_active, enUP, enDOWN}, 0);
        reset = 1'b1;
        ticks(6);
        chk("held_release_pre", adjust_active, 0);
        ticks(1);
        chk("held_release_adj", {adjust_active, en_count}, {1'b1, 4'd1});
        chk("held_release_updn", {enUP, enDOWN}, 0);
        btns = '0;
        ticks(10);

        // Short glitch ignored, long press accepted after exactly 7 edges.
        do_reset();
        press(5'b10000, 3, 12);
        chk("glitch_ignored", adjust_active, 0);
        btns = 5'b10000;
        ticks(6);
        chk("mode_edge6", en_count, 0);
        ticks(1);
        chk("mode_edge7", en_count, 1);
        ticks(3);
        btns = '0;
        ticks(10);

        // Field walk, wraps, simultaneous left/right, mode priority.
        do_reset();
        for (int i = 0; i < 13; i++) begin
            press(vecs[i].mask, vecs[i].hold, vecs[i].gap);
            chk($sformatf("vec%0d_field", i), en_count, vecs[i].exp_en);
            chk($sformatf("vec%0d_adj", i), adjust_active, vecs[i].exp_adj);
        end

        // Up/down levels on field 4.
        do_reset();
        press(5'b10000, 6, 10);
        press(5'b00100, 6, 10);
        press(5'b00100, 6, 10);
        press(5'b00100, 6, 10);
        chk("updn_field", en_count, 4);
        btns = 5'b00010;
        ticks(6);
        chk("up_edge6", enUP, 0);
        ticks(1);
        chk("up_edge7", {enUP, enDOWN}, {1'b1, 1'b0});
        ticks(13);
        btns = '0;
        ticks(6);
        chk("up_release6", enUP, 1);
        ticks(1);
        chk("up_release7", enUP, 0);
        btns = 5'b00011;
        ticks(10);
        chk("up_down_both", {enUP, enDOWN}, 0);
        btns = '0;
        ticks(10);
        btns = 5'b00001;
        ticks(8);
        chk("down_alone", {enUP, enDOWN}, {1'b0, 1'b1});
        btns = '0;
        ticks(10);

        // Timeout after TO quiet cycles, and kept alive by a held button.
        do_reset();
        btns = 5'b10000;
        ticks(6);
        btns = '0;
        ticks(55);
        chk("timeout_pre", adjust_active, 1);
        ticks(1);
        chk("timeout_adj", adjust_active, 0);
        chk("timeout_field", en_count, 0);
        btns = 5'b10000;
        ticks(6);
        btns = 5'b00010;
        ticks(80);
        chk("keepalive", {adjust_active, en_count}, {1'b1, 4'd1});
        btns = '0;
        ticks(70);
        chk("keepalive_expire", adjust_active, 0);

        // Randomized traffic against the model, with occasional resets.
        do_reset();
        for (int s = 0; s < 300; s++) begin
            logic [4:0] m;
            m[4] = ($urandom_range(0, 5) == 0);
            m[3] = ($urandom_range(0, 2) == 0);
            m[2] = ($urandom_range(0, 2) == 0);
            m[1] = ($urandom_range(0, 2) == 0);
            m[0] = ($urandom_range(0, 2) == 0);
            btns = m;
            ticks($urandom_range(1, 10));
            if ($urandom_range(0, 3) == 0) begin
                btns = '0;
                ticks($urandom_range(1, 70));
            end
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b0;
                ticks($urandom_range(1, 3));
                reset = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/control_botones_ajuste.md
# control_botones_ajuste

Pushbutton front end for the date/time adjust path. It debounces five raw board buttons and runs a field-select state machine. It drives the `en_count`, `enUP` and `enDOWN` inputs shared by every two-digit field counter (hour, minute, second, year, month, day). It sits directly upstream of those counters; only the counter whose field code matches `en_count` reacts to `enUP` and `enDOWN`.

## Interface
Parameters:
- `DB_CYCLES`, default 1_000_000: consecutive stable cycles needed to accept a button level change (10 ms at 100 MHz); must be ≥ 2.
- `TIMEOUT_CYCLES`, default 3_000_000_000: cycles without any button held before adjust mode is abandoned (30 s); 32-bit counter.

Ports:
- `clk`, in, 1: system clock, 100 MHz.
- `reset`, in, 1: one clock domain; reset is synchronous and active-low. `reset == 0` at a rising `clk` edge resets the block.
- `btn_mode`, in, 1: raw button, asynchronous, active-high; toggles adjust mode.
- `btn_left`, in, 1: raw button; selects the previous field.
- `btn_right`, in, 1: raw button; selects the next field.
- `btn_up`, in, 1: raw button; increment request.
- `btn_down`, in, 1: raw button; decrement request.
- `en_count`, out, 4: field select. 0 = none, 1 = hour, 2 = minute, 3 = second, 4 = year, 5 = month, 6 = day.
- `enUP`, out, 1: level, held increment request for the selected field.
- `enDOWN`, out, 1: level, held decrement request for the selected field.
- `adjust_active`, out, 1: high while the FSM is in ADJUST.

## Operation
- **Per-button conditioning:**
  - Each button passes through a 2-FF synchronizer, then the debouncer.
  - The debouncer holds a registered level `db`, reset value 0, and a counter.
  - The counter clears whenever the synchronized input equals `db`.
  - Otherwise the counter increments. When it reaches `DB_CYCLES-1`, `db` flips and the counter clears.
  - Rising-edge pulse `pe = db & ~db_d`, where `db_d` is a registered copy of `db`. The pulse is one cycle wide.
- **FSM state IDLE:**
  - Outputs: `en_count = 0`, `adjust_active = 0`.
  - Mode `pe` → ADJUST with field = 1.
- **FSM state ADJUST:**
  - Mode `pe` → IDLE.
  - Else, right `pe` alone: field = field+1, wrapping 6→1.
  - Else, left `pe` alone: field = field-1, wrapping 1→6.
  - Left and right `pe` in the same cycle: field unchanged.
  - Mode `pe` takes priority over left/right in the same cycle.
- **Timeout (ADJUST only):**
  - The counter clears whenever any debounced level is high, and on entry to ADJUST.
  - Otherwise it increments. Reaching `TIMEOUT_CYCLES-1` → IDLE.
- **`enUP` / `enDOWN` generation:**
  - `enUP` is registered as `db_up & ~db_down & ADJUST`.
  - `enDOWN` is registered symmetrically.
  - Both held → both 0. Never both high.
  - Both are forced to 0 in IDLE.
  - Both are forced to 0 during the cycle in which the field changes.
- **Reset values:** all outputs 0, state IDLE, all `db` = 0, all counters 0.
- **Button held through reset release:** treated as a fresh press; a `pe` is generated after debounce.

## Timing
- Raw edge to `db` change: 2 synchronizer cycles + `DB_CYCLES` cycles, for input stable throughout.
- A glitch shorter than `DB_CYCLES` synchronized cycles produces no change.
- `db` rise → `pe` high in the same cycle → `en_count` / `adjust_active` update at the next edge (1 cycle).
- `db_up` change → `enUP` change 1 cycle later.
- Leaving ADJUST (mode, timeout or reset): `en_count`, `enUP`, `enDOWN` are all 0 in the next cycle.
- Reset mid-operation: synchronous; all outputs 0 at the first edge with `reset == 0`.

## Structure
- Shared package / include holds the field codes:
  - `FIELD_NONE = 0`, `FIELD_HOUR = 1`, `FIELD_MIN = 2`, `FIELD_SEC = 3`, `FIELD_YEAR = 4`, `FIELD_MONTH = 5`, `FIELD_DAY = 6`.
  - `FIELD_FIRST = 1`, `FIELD_LAST = 6`.
  - The field counters use the same codes.
- FSM state encoding is local.
- One sub-module: `debounce_boton`, covering synchronizer, debounce counter, `db` level and `pe` pulse; parameter `DB_CYCLES`. It is instantiated five times.

## Test plan
All scenarios use `DB_CYCLES = 4` and `TIMEOUT_CYCLES = 50`.
- **Reset:** hold `reset = 0` for 3 cycles with all buttons high → all outputs 0. Release with buttons high → after 6 cycles mode `pe`; `adjust_active = 1`, `en_count = 1`.
- **Debounce:** pulse `btn_mode` high for 3 cycles → no state change. Hold for 10 cycles → `en_count` goes 0→1 exactly 7 cycles after the raw rise.
- **Field wrap:** in ADJUST at field 6, press right → 1. Press left → 6. Press left and right together → unchanged.
- **Up/down:** field 4, hold `btn_up` 20 cycles → `enUP = 1` from cycle 7 until 7 cycles after release, `enDOWN = 0`. Press `btn_down` and `btn_up` together → both outputs 0.
- **Timeout:** enter ADJUST, leave buttons idle 50 cycles → `en_count = 0`, `adjust_active = 0`. Holding `btn_up` keeps ADJUST alive past 50 cycles.
- **Priority:** mode and right `pe` in the same cycle while in ADJUST → IDLE, `en_count = 0`.
